// File: rtl/onehot_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_mon_pkg
//  Description : Shared types and helpers for the one-hot state monitor.
//                Defines the monitor FSM state type and width-agnostic
//                helpers that test a vector for one-hot encoding and rotate
//                it left by one position within its live width.
//  Revision    : 1.0 - initial release
// ============================================================================
package onehot_mon_pkg;

    // Helpers work on a fixed-width carrier. Callers size-cast into and out
    // of it and pass the live width in n, so one function serves every N.
    localparam int c_VEC_W = 64;

    typedef enum logic [1:0] {
        MON_IDLE    = 2'd0,
        MON_TRACK   = 2'd1,
        MON_FAULT   = 2'd2,
        MON_RECOVER = 2'd3
    } mon_state_e;

    // Mask of the low n bits. n == c_VEC_W wraps to 0 - 1, i.e. all ones.
    function automatic logic [c_VEC_W-1:0] live_mask(input int n);
        live_mask = (c_VEC_W'(1) << n) - c_VEC_W'(1);
    endfunction

    // Exactly one bit set within the low n bits.
    function automatic logic is_onehot(input logic [c_VEC_W-1:0] vec,
                                       input int                 n);
        is_onehot = ($countones(vec & live_mask(n)) == 1);
    endfunction

    // Rotate left by one within the low n bits; the MSB wraps to bit 0.
    function automatic logic [c_VEC_W-1:0] rotl1(input logic [c_VEC_W-1:0] vec,
                                                 input int                 n);
        logic [c_VEC_W-1:0] v;
        v     = vec & live_mask(n);
        rotl1 = ((v << 1) | (v >> (n - 1))) & live_mask(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_state_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_state_monitor_if
//  Description : Bundle between the one-hot FSM side (master) and the
//                monitor (slave).
//                Master drives : en, clr, state
//                Slave drives  : onehot_ok, illegal_pulse, bad_trans,
//                                err_sticky, err_count, stuck, recover_req,
//                                last_good_state
//  Revision    : 1.0 - initial release
// ============================================================================
interface onehot_state_monitor_if #(
    parameter int N         = 3,
    parameter int ERR_CNT_W = 8
);
    logic                 en;
    logic                 clr;
    logic [N-1:0]         state;
    logic                 onehot_ok;
    logic                 illegal_pulse;
    logic                 bad_trans;
    logic                 err_sticky;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 stuck;
    logic                 recover_req;
    logic [N-1:0]         last_good_state;

    modport master (
        output en, clr, state,
        input  onehot_ok, illegal_pulse, bad_trans, err_sticky,
               err_count, stuck, recover_req, last_good_state
    );

    modport slave (
        input  en, clr, state,
        output onehot_ok, illegal_pulse, bad_trans, err_sticky,
               err_count, stuck, recover_req, last_good_state
    );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that saturates at LIMIT.
//                i_clr alone loads 0; i_clr with i_inc loads 1 (restart a
//                count on the current sample); i_inc alone counts up to
//                LIMIT and holds there.
//  Ports       : clk, rst (async, active-low), i_inc, i_clr, o_count
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] LIMIT = '1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_inc,
    input  wire logic             i_clr,
    output logic      [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= i_inc ? WIDTH'(1) : '0;
        end else if (i_inc && (r_count != LIMIT)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/onehot_state_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_state_monitor
//  Description : Registered checker downstream of a one-hot ring FSM.
//                Flags non-one-hot vectors and illegal ring steps, detects a
//                stuck state, keeps a saturating error count plus a sticky
//                error flag, and requests recovery after a run of
//                non-one-hot samples. One cycle of latency on all outputs.
//  Ports       : clk        - clock
//                rst        - asynchronous reset, active low
//                mon        - slave side of onehot_state_monitor_if
//                             (en, clr, state in; status/counters out)
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_state_monitor
    import onehot_mon_pkg::*;
#(
    parameter int N              = 3,
    parameter int ERR_CNT_W      = 8,
    parameter int DWELL_W        = 8,
    parameter int MAX_DWELL      = 16,
    parameter int RECOVER_THRESH = 2
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    onehot_state_monitor_if.slave     mon
);

    localparam int c_RUN_W = $clog2(RECOVER_THRESH + 1);

    mon_state_e           r_state;
    logic                 r_onehot_ok;
    logic                 r_illegal;
    logic                 r_bad_trans;
    logic                 r_sticky;
    logic                 r_recover;
    logic [N-1:0]         r_last_good;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic [DWELL_W-1:0]   r_dwell;
    logic [c_RUN_W-1:0]   r_bad_run;

    logic                 w_ok;
    logic [N-1:0]         w_succ;
    logic                 w_tracking;
    logic                 w_hold;
    logic                 w_bad;
    logic                 w_illegal;
    logic                 w_run_hit;

    // ------------------------------------------------------------------
    // Sample classification
    // ------------------------------------------------------------------
    assign w_ok       = is_onehot(c_VEC_W'(mon.state), N);
    assign w_succ     = N'(rotl1(c_VEC_W'(r_last_good), N));
    // Transition checks only apply once a legal reference is being
    // tracked; first samples out of IDLE or FAULT are taken as-is.
    assign w_tracking = (r_state == MON_TRACK);
    assign w_hold     = w_tracking && w_ok && (mon.state == r_last_good);
    assign w_bad      = w_tracking && w_ok && !w_hold && (mon.state != w_succ);
    assign w_illegal  = !w_ok || w_bad;
    // This non-one-hot sample completes the run of RECOVER_THRESH.
    assign w_run_hit  = !w_ok && (int'(r_bad_run) >= (RECOVER_THRESH - 1));

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    // A clr on the same sample as an error drops that error's count.
    sat_counter #(
        .WIDTH (ERR_CNT_W),
        .LIMIT ('1)
    ) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (mon.en && w_illegal && !mon.clr),
        .i_clr   (mon.en && mon.clr),
        .o_count (r_err_count)
    );

    // Dwell: hold increments; any other legal sample restarts at 1
    // (clr+inc); non-one-hot or clr zeroes it.
    sat_counter #(
        .WIDTH (DWELL_W),
        .LIMIT (DWELL_W'(MAX_DWELL))
    ) u_dwell_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (mon.en && w_ok && !mon.clr),
        .i_clr   (mon.en && (mon.clr || !w_ok || !w_hold)),
        .o_count (r_dwell)
    );

    // Run of consecutive non-one-hot samples; any legal sample ends it.
    sat_counter #(
        .WIDTH (c_RUN_W),
        .LIMIT (c_RUN_W'(RECOVER_THRESH))
    ) u_run_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (mon.en && !w_ok),
        .i_clr   (mon.en && w_ok),
        .o_count (r_bad_run)
    );

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= MON_IDLE;
            r_onehot_ok <= 1'b0;
            r_illegal   <= 1'b0;
            r_bad_trans <= 1'b0;
            r_sticky    <= 1'b0;
            r_recover   <= 1'b0;
            r_last_good <= '0;
        end else if (mon.en) begin
            r_onehot_ok <= w_ok;
            r_illegal   <= w_illegal;
            r_bad_trans <= w_bad;

            if (mon.clr) begin
                r_sticky <= 1'b0;
            end else if (w_illegal) begin
                r_sticky <= 1'b1;
            end

            // Legal samples always become the new reference, including a
            // bad transition, so the checker re-syncs to the FSM.
            if (w_ok) begin
                r_last_good <= mon.state;
            end

            case (r_state)
                MON_IDLE, MON_TRACK, MON_FAULT: begin
                    if (w_ok) begin
                        r_state   <= MON_TRACK;
                        r_recover <= 1'b0;
                    end else if (w_run_hit) begin
                        r_state   <= MON_RECOVER;
                        r_recover <= 1'b1;
                    end else begin
                        r_state   <= MON_FAULT;
                        r_recover <= 1'b0;
                    end
                end
                MON_RECOVER: begin
                    if (w_ok) begin
                        r_state   <= MON_TRACK;
                        r_recover <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= MON_IDLE;
                    r_recover <= 1'b0;
                end
            endcase
        end else begin
            // Pulses never stretch across disabled cycles.
            r_illegal   <= 1'b0;
            r_bad_trans <= 1'b0;
        end
    end

    assign mon.onehot_ok       = r_onehot_ok;
    assign mon.illegal_pulse   = r_illegal;
    assign mon.bad_trans       = r_bad_trans;
    assign mon.err_sticky      = r_sticky;
    assign mon.err_count       = r_err_count;
    assign mon.stuck           = (r_dwell == DWELL_W'(MAX_DWELL));
    assign mon.recover_req     = r_recover;
    assign mon.last_good_state = r_last_good;

endmodule
`default_nettype wire

// File: tb/tb_onehot_state_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onehot_state_monitor
//  Description : Self-checking bench for onehot_state_monitor. Two instances
//                (default parameters and a small-counter variant) share one
//                stimulus stream and are compared against a behavioural
//                model, a directed vector table and hand-written sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_state_monitor;

    localparam int c_N     = 3;
    localparam int c_CW1   = 8;
    localparam int c_MAXD1 = 16;
    localparam int c_THR1  = 2;
    localparam int c_CW2   = 2;
    localparam int c_MAXD2 = 5;
    localparam int c_THR2  = 1;

    logic           clk;
    logic           rst;
    logic           en;
    logic           clr;
    logic [c_N-1:0] st;

    int n_checks = 0;
    int n_errors = 0;

    onehot_state_monitor_if #(.N(c_N), .ERR_CNT_W(c_CW1)) bus1 ();
    onehot_state_monitor_if #(.N(c_N), .ERR_CNT_W(c_CW2)) bus2 ();

    assign bus1.en    = en;
    assign bus1.clr   = clr;
    assign bus1.state = st;
    assign bus2.en    = en;
    assign bus2.clr   = clr;
    assign bus2.state = st;

    onehot_state_monitor #(
        .N(c_N), .ERR_CNT_W(c_CW1), .DWELL_W(8),
        .MAX_DWELL(c_MAXD1), .RECOVER_THRESH(c_THR1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .mon (bus1.slave)
    );

    onehot_state_monitor #(
        .N(c_N), .ERR_CNT_W(c_CW2), .DWELL_W(3),
        .MAX_DWELL(c_MAXD2), .RECOVER_THRESH(c_THR2)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .mon (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural reference: the monitor as a description of the sample
    // history (is there a tracked reference, how long is the current
    // run of bad vectors, how long has the state dwelt).
    // ------------------------------------------------------------------
    typedef struct {
        bit tracking;
        int lgs;
        int dwell;
        int run;
        int errc;
        bit sticky;
        bit ok;
        bit ip;
        bit bt;
    } mdl_t;

    mdl_t m1, m2;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.tracking = 0; m.lgs = 0; m.dwell = 0; m.run = 0; m.errc = 0;
        m.sticky = 0; m.ok = 0; m.ip = 0; m.bt = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t mi, bit e, bit c, int s,
                                      int cw, int maxd);
        mdl_t m = mi;
        int   ones = 0;
        int   succ;
        bit   hold;
        if (!e) begin
            m.ip = 0;
            m.bt = 0;
            return m;
        end
        for (int b = 0; b < c_N; b++) ones += (s >> b) & 1;
        m.ok = (ones == 1);
        m.bt = 0;
        if (m.ok) begin
            succ = (m.lgs == (1 << (c_N - 1))) ? 1 : m.lgs * 2;
            hold = m.tracking && (s == m.lgs);
            if (m.tracking && !hold && s != succ) m.bt = 1;
            m.dwell    = hold ? ((m.dwell + 1 > maxd) ? maxd : m.dwell + 1) : 1;
            m.lgs      = s;
            m.tracking = 1;
            m.run      = 0;
        end else begin
            m.tracking = 0;
            m.dwell    = 0;
            if (m.run < 1000) m.run++;
        end
        m.ip = !m.ok || m.bt;
        if (c) begin
            m.errc   = 0;
            m.sticky = 0;
            m.dwell  = 0;
        end else if (m.ip) begin
            if (m.errc < (1 << cw) - 1) m.errc++;
            m.sticky = 1;
        end
        return m;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m1 = mdl_reset();
            m2 = mdl_reset();
        end else begin
            m1 = mdl_step(m1, en, clr, int'(st), c_CW1, c_MAXD1);
            m2 = mdl_step(m2, en, clr, int'(st), c_CW2, c_MAXD2);
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model(string tag, mdl_t m, int maxd, int thr,
                             logic ok, logic ip, logic bt, logic [31:0] cnt,
                             logic sticky, logic stuck, logic rr,
                             logic [31:0] lgs);
        check({tag, ".onehot_ok"},       32'(ok),     32'(m.ok));
        check({tag, ".illegal_pulse"},   32'(ip),     32'(m.ip));
        check({tag, ".bad_trans"},       32'(bt),     32'(m.bt));
        check({tag, ".err_count"},       cnt,         m.errc);
        check({tag, ".err_sticky"},      32'(sticky), 32'(m.sticky));
        check({tag, ".stuck"},           32'(stuck),  32'(m.dwell >= maxd));
        check({tag, ".recover_req"},     32'(rr),     32'(m.run >= thr));
        check({tag, ".last_good_state"}, lgs,         m.lgs);
    endtask

    task automatic cmp_both(string tag);
        cmp_model({tag, "/d1"}, m1, c_MAXD1, c_THR1,
                  bus1.onehot_ok, bus1.illegal_pulse, bus1.bad_trans,
                  32'(bus1.err_count), bus1.err_sticky, bus1.stuck,
                  bus1.recover_req, 32'(bus1.last_good_state));
        cmp_model({tag, "/d2"}, m2, c_MAXD2, c_THR2,
                  bus2.onehot_ok, bus2.illegal_pulse, bus2.bad_trans,
                  32'(bus2.err_count), bus2.err_sticky, bus2.stuck,
                  bus2.recover_req, 32'(bus2.last_good_state));
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "/d1.outs"},
              {bus1.onehot_ok, bus1.illegal_pulse, bus1.bad_trans,
               bus1.err_sticky, bus1.stuck, bus1.recover_req,
               bus1.last_good_state, bus1.err_count}, 32'd0);
        check({tag, "/d2.outs"},
              {bus2.onehot_ok, bus2.illegal_pulse, bus2.bad_trans,
               bus2.err_sticky, bus2.stuck, bus2.recover_req,
               bus2.last_good_state, bus2.err_count}, 32'd0);
    endtask

    // Apply one sample and look at the result 1 ns after the edge.
    task automatic step(bit e, bit c, logic [c_N-1:0] s);
        en  = e;
        clr = c;
        st  = s;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table (expectations for dut1, default parameters)
    // ------------------------------------------------------------------
    typedef struct {
        bit             en;
        bit             clr;
        logic [c_N-1:0] st;
        bit             ok;
        bit             ip;
        bit             bt;
        int             cnt;
        bit             sticky;
        bit             rr;
        logic [c_N-1:0] lgs;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int lgs_r;
        int s_r;
        int r;

        //            en clr st      ok ip bt cnt sty rr lgs
        tbl[0]  = '{1, 0, 3'b001, 1, 0, 0, 0, 0, 0, 3'b001}; // first legal
        tbl[1]  = '{1, 0, 3'b010, 1, 0, 0, 0, 0, 0, 3'b010}; // ring
        tbl[2]  = '{1, 0, 3'b100, 1, 0, 0, 0, 0, 0, 3'b100};
        tbl[3]  = '{1, 0, 3'b001, 1, 0, 0, 0, 0, 0, 3'b001}; // wrap
        tbl[4]  = '{1, 0, 3'b110, 0, 1, 0, 1, 1, 0, 3'b001}; // multi-hot
        tbl[5]  = '{1, 0, 3'b110, 0, 1, 0, 2, 1, 1, 3'b001}; // run hits 2
        tbl[6]  = '{1, 0, 3'b001, 1, 0, 0, 2, 1, 0, 3'b001}; // recovered
        tbl[7]  = '{1, 0, 3'b100, 1, 1, 1, 3, 1, 0, 3'b100}; // skip step
        tbl[8]  = '{0, 0, 3'b000, 1, 0, 0, 3, 1, 0, 3'b100}; // disabled
        tbl[9]  = '{1, 1, 3'b000, 0, 1, 0, 0, 0, 0, 3'b100}; // clr wins
        tbl[10] = '{1, 0, 3'b001, 1, 0, 0, 0, 0, 0, 3'b001}; // out of FAULT

        en = 0; clr = 0; st = '0; rst = 1'b0;

        // Reset state
        #9;
        check_all_zero("reset");
        #1 rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].en, tbl[i].clr, tbl[i].st);
            check($sformatf("tbl[%0d].onehot_ok", i),     32'(bus1.onehot_ok),       32'(tbl[i].ok));
            check($sformatf("tbl[%0d].illegal_pulse", i), 32'(bus1.illegal_pulse),   32'(tbl[i].ip));
            check($sformatf("tbl[%0d].bad_trans", i),     32'(bus1.bad_trans),       32'(tbl[i].bt));
            check($sformatf("tbl[%0d].err_count", i),     32'(bus1.err_count),       tbl[i].cnt);
            check($sformatf("tbl[%0d].err_sticky", i),    32'(bus1.err_sticky),      32'(tbl[i].sticky));
            check($sformatf("tbl[%0d].recover_req", i),   32'(bus1.recover_req),     32'(tbl[i].rr));
            check($sformatf("tbl[%0d].lgs", i),           32'(bus1.last_good_state), 32'(tbl[i].lgs));
            cmp_both($sformatf("tbl[%0d]", i));
        end

        // Stuck: 010 is the successor of 001, so dwell starts at 1.
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 3'b010);
            cmp_both($sformatf("dwell%0d", i));
            if (i == 15) check("stuck.before", 32'(bus1.stuck), 32'd0);
        end
        check("stuck.at16", 32'(bus1.stuck), 32'd1);
        step(1, 0, 3'b100);
        check("stuck.released", 32'(bus1.stuck), 32'd0);
        cmp_both("stuck.next");

        // Saturation on the 2-bit counter, then clr against an error.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 3'b000);
            cmp_both($sformatf("sat%0d", i));
        end
        check("sat.d2_count", 32'(bus2.err_count), 32'd3);
        check("sat.d1_count", 32'(bus1.err_count), 32'd4);
        step(1, 1, 3'b000);
        check("clr.d2_count",  32'(bus2.err_count),     32'd0);
        check("clr.d2_sticky", 32'(bus2.err_sticky),    32'd0);
        check("clr.d2_pulse",  32'(bus2.illegal_pulse), 32'd1);
        check("clr.d1_recover_kept", 32'(bus1.recover_req), 32'd1);
        cmp_both("clr");

        // Async reset while in recovery, away from the clock edge.
        #2 rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 3'b100);
        check("post_rst.onehot_ok", 32'(bus1.onehot_ok), 32'd1);
        check("post_rst.bad_trans", 32'(bus1.bad_trans), 32'd0);
        check("post_rst.lgs",       32'(bus1.last_good_state), 32'd4);
        cmp_both("post_rst");

        // Randomised run, mostly ring-like traffic with injected faults.
        for (int i = 0; i < 3000; i++) begin
            lgs_r = (m1.lgs == 0) ? 1 : m1.lgs;
            r     = int'($urandom_range(0, 9));
            if (r < 5)      s_r = (lgs_r == 4) ? 1 : lgs_r * 2;
            else if (r < 7) s_r = lgs_r;
            else            s_r = int'($urandom_range(0, 7));
            en  = ($urandom_range(0, 9) != 0);
            clr = en && ($urandom_range(0, 39) == 0);
            step(en, clr, 3'(s_r));
            cmp_both($sformatf("rnd%0d", i));
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                #1;
                check_all_zero($sformatf("rnd_rst%0d", i));
                rst = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
